// File: rtl/cell_segmenter_pkg.sv
// cell_segmenter_pkg: shared constants, state encoding and pointer-word
// helper for the cell segmenter.
//   CELL_WORDS / WORD_BYTES : cell geometry (4 x 128-bit words, 16 bytes each)
//   PTR_* : field positions inside the 16-bit cell pointer word
//   seg_state_t : segmenter FSM state encoding
//   make_ptr() : assembles a pointer word from portmap and cell count
package cell_segmenter_pkg;

  localparam int CELL_WORDS      = 4;
  localparam int WORD_BYTES      = 16;
  localparam int WORD_BITS       = WORD_BYTES * 8;
  localparam int PTR_PORTMAP_LSB = 8;
  localparam int PTR_PORTMAP_W   = 4;
  localparam int PTR_COUNT_LSB   = 0;
  localparam int PTR_COUNT_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_PTR,
    ST_DROP
  } seg_state_t;

  // Unused pointer bits stay zero.
  function automatic logic [15:0] make_ptr(input logic [PTR_PORTMAP_W-1:0] portmap,
                                           input logic [PTR_COUNT_W-1:0]   count);
    logic [15:0] w;
    w = '0;
    w[PTR_PORTMAP_LSB +: PTR_PORTMAP_W] = portmap;
    w[PTR_COUNT_LSB   +: PTR_COUNT_W]   = count;
    return w;
  endfunction

endpackage

// File: rtl/cell_segmenter_if.sv
// cell_segmenter_if: groups the byte ingress handshake and the switch-core
// cell write bus.
//   slave  : the segmenter (consumes bytes, drives cell data/pointer writes)
//   master : the environment (drives bytes and backpressure)
interface cell_segmenter_if;
  import cell_segmenter_pkg::*;

  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_last;
  logic [3:0]           in_portmap;
  logic                 in_ready;
  logic [WORD_BITS-1:0] cell_data_din;
  logic                 cell_data_wr;
  logic [15:0]          cell_ptr_din;
  logic                 cell_ptr_wr;
  logic                 cell_bp;

  modport slave (
    input  in_data, in_valid, in_last, in_portmap, cell_bp,
    output in_ready, cell_data_din, cell_data_wr, cell_ptr_din, cell_ptr_wr
  );

  modport master (
    output in_data, in_valid, in_last, in_portmap, cell_bp,
    input  in_ready, cell_data_din, cell_data_wr, cell_ptr_din, cell_ptr_wr
  );

endinterface

// File: rtl/cell_byte_packer.sv
// cell_byte_packer: packs bytes into 128-bit words, byte 0 in the top lane.
//   byte_data/byte_we : byte to store this cycle
//   flush             : with byte_we, the byte is the last one; emit the word zero-filled
//   pad               : emit an all-zero word (ignored when byte_we is high)
//   word_data/word_wr : registered word and one-cycle write strobe
//   word_full         : the next stored byte completes the word
//   word_empty        : no bytes currently held
module cell_byte_packer
  import cell_segmenter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           byte_data,
  input  logic                 byte_we,
  input  logic                 flush,
  input  logic                 pad,
  output logic [WORD_BITS-1:0] word_data,
  output logic                 word_wr,
  output logic                 word_full,
  output logic                 word_empty
);

  logic [3:0]           idx_reg;
  logic [WORD_BITS-1:0] acc_reg;
  logic [WORD_BITS-1:0] merged;
  logic [WORD_BITS-1:0] word_data_reg;
  logic                 word_wr_reg;

  // The accumulator is cleared after every word, so lanes past the current
  // index are already zero and a flush needs no extra masking.
  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign merged[WORD_BITS-1-8*gi -: 8] =
        (idx_reg == 4'(gi)) ? byte_data : acc_reg[WORD_BITS-1-8*gi -: 8];
    end
  endgenerate

  assign word_full  = (idx_reg == 4'(WORD_BYTES - 1));
  assign word_empty = (idx_reg == 4'd0);
  assign word_data  = word_data_reg;
  assign word_wr    = word_wr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg       <= '0;
      acc_reg       <= '0;
      word_data_reg <= '0;
      word_wr_reg   <= 1'b0;
    end else begin
      word_wr_reg <= 1'b0;
      if (byte_we) begin
        if (flush || word_full) begin
          word_data_reg <= merged;
          word_wr_reg   <= 1'b1;
          acc_reg       <= '0;
          idx_reg       <= '0;
        end else begin
          acc_reg <= merged;
          idx_reg <= idx_reg + 4'd1;
        end
      end else if (pad) begin
        word_data_reg <= '0;
        word_wr_reg   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cell_segmenter.sv
// cell_segmenter: cuts ingress frames into 64-byte cells (4 x 128-bit words),
// zero-pads the final cell, then writes one pointer word per frame.
//   clk, rst     : clock and asynchronous active-high reset
//   bus          : byte ingress + cell data/pointer write bus (slave side)
//   err_oversize : one-cycle pulse when a frame exceeds MAX_CELLS cells
//   frame_cnt    : number of pointer words written (wraps)
module cell_segmenter
  import cell_segmenter_pkg::*;
#(
  parameter int MAX_CELLS = 24
) (
  input  logic             clk,
  input  logic             rst,
  cell_segmenter_if.slave  bus,
  output logic             err_oversize,
  output logic [15:0]      frame_cnt
);

  localparam logic [1:0] LAST_WORD = 2'(CELL_WORDS - 1);

  seg_state_t  state_reg, state_next;
  logic [1:0]  word_idx_reg, word_idx_cur;
  logic [5:0]  cell_cnt_reg, cell_cnt_cur;
  logic [3:0]  portmap_reg;
  logic        in_ready_reg, in_ready_next;
  logic [15:0] ptr_din_reg;
  logic        ptr_wr_reg;
  logic        err_reg;
  logic [15:0] frame_cnt_reg;

  logic accept, byte_we, flush, pad, word_done, clear, ptr_fire, oversize;
  logic word_full, word_empty, cell_limit;

  cell_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_data  (bus.in_data),
    .byte_we    (byte_we),
    .flush      (flush),
    .pad        (pad),
    .word_data  (bus.cell_data_din),
    .word_wr    (bus.cell_data_wr),
    .word_full  (word_full),
    .word_empty (word_empty)
  );

  // Backpressure only gates the start of a frame; once filling, the core's
  // margin absorbs a whole maximum-size frame.
  assign bus.in_ready = in_ready_reg && !((state_reg == ST_IDLE) && bus.cell_bp);
  assign accept       = bus.in_valid && bus.in_ready;
  // A byte arriving on a cell boundary with the cell budget used up would
  // open one cell too many.
  assign cell_limit   = word_empty && (word_idx_reg == 2'd0) &&
                        (cell_cnt_reg == 6'(MAX_CELLS));

  always_comb begin
    state_next = state_reg;
    byte_we    = 1'b0;
    flush      = 1'b0;
    pad        = 1'b0;
    word_done  = 1'b0;
    clear      = 1'b0;
    ptr_fire   = 1'b0;
    oversize   = 1'b0;
    case (state_reg)
      ST_IDLE: if (accept) begin
        clear      = 1'b1;
        byte_we    = 1'b1;
        flush      = bus.in_last;
        word_done  = bus.in_last;
        state_next = bus.in_last ? ST_PAD : ST_FILL;
      end
      ST_FILL: if (accept) begin
        if (cell_limit) begin
          oversize   = 1'b1;
          state_next = bus.in_last ? ST_PTR : ST_DROP;
        end else begin
          byte_we   = 1'b1;
          flush     = bus.in_last;
          word_done = bus.in_last || word_full;
          if (bus.in_last)
            state_next = (word_idx_reg == LAST_WORD) ? ST_PTR : ST_PAD;
        end
      end
      ST_PAD: begin
        pad       = 1'b1;
        word_done = 1'b1;
        if (word_idx_reg == LAST_WORD)
          state_next = ST_PTR;
      end
      ST_DROP: if (accept && bus.in_last) state_next = ST_PTR;
      ST_PTR: begin
        ptr_fire   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Counters restart from zero on the first byte of a frame.
  assign word_idx_cur = clear ? 2'd0 : word_idx_reg;
  assign cell_cnt_cur = clear ? 6'd0 : cell_cnt_reg;

  // Readiness is registered from the next state. After a pointer write the
  // segmenter sits one extra cycle in IDLE unready, so the pointer reaches
  // the core (and its backpressure can react) before the next frame starts.
  always_comb begin
    case (state_next)
      ST_FILL, ST_DROP: in_ready_next = 1'b1;
      ST_IDLE:          in_ready_next = (state_reg == ST_IDLE);
      default:          in_ready_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      word_idx_reg  <= '0;
      cell_cnt_reg  <= '0;
      portmap_reg   <= '0;
      in_ready_reg  <= 1'b0;
      ptr_din_reg   <= '0;
      ptr_wr_reg    <= 1'b0;
      err_reg       <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= in_ready_next;
      err_reg      <= oversize;
      ptr_wr_reg   <= ptr_fire;
      if (clear)
        portmap_reg <= bus.in_portmap;
      word_idx_reg <= word_done ? word_idx_cur + 2'd1 : word_idx_cur;
      cell_cnt_reg <= (word_done && (word_idx_cur == LAST_WORD)) ? cell_cnt_cur + 6'd1
                                                                  : cell_cnt_cur;
      if (ptr_fire) begin
        ptr_din_reg   <= make_ptr(portmap_reg, cell_cnt_reg);
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign bus.cell_ptr_din = ptr_din_reg;
  assign bus.cell_ptr_wr  = ptr_wr_reg;
  assign err_oversize     = err_reg;
  assign frame_cnt        = frame_cnt_reg;

endmodule

// File: tb/tb_cell_segmenter.sv
// tb_cell_segmenter: scoreboard bench. Stimulus pushes expected cell words and
// pointer words computed from frame length/content; a negedge monitor pops and
// compares whenever the DUT writes.
module tb_cell_segmenter;

  localparam int MAXC = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_oversize;
  logic [15:0] frame_cnt;

  cell_segmenter_if bus ();

  cell_segmenter #(.MAX_CELLS(MAXC)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .err_oversize (err_oversize),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_data_q[$];
  logic [15:0]  exp_ptr_q[$];
  int           exp_ptr_words_q[$];
  int data_pushed = 0;
  int data_seen = 0;
  int frames_seen = 0;
  int err_seen = 0;
  int err_exp = 0;
  logic [7:0] frame_buf [0:2047];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Reference model: keep at most MAXC*64 bytes, round up to whole cells,
  // zero beyond the frame; byte k of a word sits in bits [127-8k -: 8].
  task automatic push_model(input int len, input logic [3:0] pm);
    int kept, cells;
    logic [127:0] w;
    kept  = (len > MAXC * 64) ? MAXC * 64 : len;
    cells = (kept + 63) / 64;
    if (len > MAXC * 64) err_exp++;
    for (int wi = 0; wi < cells * 4; wi++) begin
      w = '0;
      for (int b = 0; b < 16; b++)
        if (wi * 16 + b < kept) w[127 - 8 * b -: 8] = frame_buf[wi * 16 + b];
      exp_data_q.push_back(w);
    end
    data_pushed += cells * 4;
    exp_ptr_q.push_back((16'(pm) << 8) | 16'(cells));
    exp_ptr_words_q.push_back(data_pushed);
    $display("frame len=%0d portmap=%b cells=%0d", len, pm, cells);
  endtask

  task automatic drive_bytes(input int len, input logic [3:0] pm, input int gap_pct,
                             input int bp_at, input bit with_last, input bit rand_bp,
                             output int span);
    int i, stall, first, cyc;
    bit acc;
    i = 0; stall = 0; first = -1; cyc = 0; span = 0;
    while (i < len) begin
      if (rand_bp) bus.cell_bp = ($urandom_range(3) == 0);
      if (bp_at >= 0 && i >= bp_at) bus.cell_bp = 1'b1;
      bus.in_valid   = !(gap_pct > 0 && $urandom_range(99) < gap_pct);
      bus.in_data    = frame_buf[i];
      bus.in_last    = with_last && (i == len - 1);
      bus.in_portmap = (i == 0) ? pm : 4'($urandom);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        if (first < 0) first = cyc;
        span = cyc - first;
        i++;
        stall = 0;
      end else begin
        stall++;
        if (stall > 200) begin
          checks++;
          failures++;
          $display("FAIL drive_timeout byte=%0d act=stalled exp=accepted", i);
          break;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (bp_at >= 0 || rand_bp) bus.cell_bp = 1'b0;
  endtask

  task automatic send(input int len, input logic [3:0] pm, input int gap_pct, input bit rand_bp);
    int span;
    push_model(len, pm);
    drive_bytes(len, pm, gap_pct, -1, 1'b1, rand_bp, span);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_data_q.size() != 0 || exp_ptr_q.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout act=%0d/%0d pending exp=0", exp_data_q.size(), exp_ptr_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [127:0] ew;
    logic [15:0]  ep;
    int           en;
    if (rst) begin
      data_seen   = 0;
      frames_seen = 0;
    end else begin
      if (bus.cell_ptr_wr) begin
        if (exp_ptr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ptr_unexpected act=%h exp=none", bus.cell_ptr_din);
        end else begin
          ep = exp_ptr_q.pop_front();
          en = exp_ptr_words_q.pop_front();
          check("ptr_word", 128'(bus.cell_ptr_din), 128'(ep));
          check("ptr_after_data", 128'(data_seen), 128'(en));
        end
        frames_seen++;
        check("frame_cnt", 128'(frame_cnt), 128'(16'(frames_seen)));
      end
      if (bus.cell_data_wr) begin
        if (exp_data_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL data_unexpected act=%h exp=none", bus.cell_data_din);
        end else begin
          ew = exp_data_q.pop_front();
          check("data_word", bus.cell_data_din, ew);
        end
        data_seen++;
      end
      if (err_oversize) err_seen++;
    end
  end

  initial begin
    int span, nacc, cyc, prev;
    bit acc;
    logic [3:0] pm;
    logic [7:0] d1 [4];
    logic [3:0] pms [4];
    logic [127:0] w;

    rst = 1'b1;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.in_portmap = '0; bus.cell_bp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 128'(bus.in_ready), 128'(0));
    check("rst_data_wr", 128'(bus.cell_data_wr), 128'(0));
    check("rst_ptr_wr", 128'(bus.cell_ptr_wr), 128'(0));
    check("rst_err", 128'(err_oversize), 128'(0));
    check("rst_data_din", bus.cell_data_din, 128'(0));
    check("rst_ptr_din", 128'(bus.cell_ptr_din), 128'(0));
    check("rst_frame_cnt", 128'(frame_cnt), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 64-byte and 65-byte incrementing frames
    for (int i = 0; i < 65; i++) frame_buf[i] = 8'(i);
    send(64, 4'b0010, 0, 1'b0);
    send(65, 4'b1001, 0, 1'b0);
    wait_drain();

    // Backpressure in IDLE, then rising mid-frame
    for (int i = 0; i < 40; i++) frame_buf[i] = 8'($urandom);
    pm = 4'b0100;
    bus.cell_bp = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = frame_buf[0]; bus.in_last = 1'b0; bus.in_portmap = pm;
    repeat (8) begin
      @(negedge clk);
      check("bp_idle_ready", 128'(bus.in_ready), 128'(0));
      @(posedge clk);
      #1;
    end
    bus.cell_bp = 1'b0;
    push_model(40, pm);
    drive_bytes(40, pm, 0, 20, 1'b1, 1'b0, span);
    check("fill_ignores_bp", 128'(span), 128'(39));
    wait_drain();

    // Back-to-back single-byte frames with in_valid held
    for (int f = 0; f < 4; f++) begin
      d1[f] = 8'($urandom);
      pms[f] = 4'($urandom);
      frame_buf[0] = d1[f];
      push_model(1, pms[f]);
    end
    bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.in_data = d1[0]; bus.in_portmap = pms[0];
    nacc = 0; cyc = 0; prev = -1;
    while (nacc < 4 && cyc < 200) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        if (prev >= 0) check("b2b_gap", 128'(cyc - prev), 128'(6));
        prev = cyc;
        nacc++;
        if (nacc < 4) begin
          bus.in_data = d1[nacc];
          bus.in_portmap = pms[nacc];
        end
      end
    end
    if (nacc < 4) begin
      checks++;
      failures++;
      $display("FAIL b2b_timeout act=%0d exp=4", nacc);
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    wait_drain();

    // Oversize frame
    for (int i = 0; i < 1600; i++) frame_buf[i] = 8'($urandom);
    send(1600, 4'b1111, 10, 1'b0);
    wait_drain();
    check("err_after_oversize", 128'(err_seen), 128'(1));

    // Randomised frames, including portmap 0, gaps and backpressure
    for (int f = 0; f < 25; f++) begin
      int len;
      len = (f % 5 == 0) ? 64 * (1 + $urandom_range(2)) : 1 + $urandom_range(299);
      for (int i = 0; i < len; i++) frame_buf[i] = 8'($urandom);
      send(len, (f % 7 == 0) ? 4'b0000 : 4'($urandom), 20, 1'b1);
    end
    wait_drain();

    // Reset after byte 20: only the first full word reaches the core
    for (int i = 0; i < 20; i++) frame_buf[i] = 8'($urandom);
    w = '0;
    for (int b = 0; b < 16; b++) w[127 - 8 * b -: 8] = frame_buf[b];
    exp_data_q.push_back(w);
    drive_bytes(20, 4'b0011, 0, -1, 1'b0, 1'b0, span);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 128'(bus.in_ready), 128'(0));
    check("mid_rst_data_wr", 128'(bus.cell_data_wr), 128'(0));
    check("mid_rst_ptr_wr", 128'(bus.cell_ptr_wr), 128'(0));
    check("mid_rst_data_din", bus.cell_data_din, 128'(0));
    check("mid_rst_ptr_din", 128'(bus.cell_ptr_din), 128'(0));
    check("mid_rst_frame_cnt", 128'(frame_cnt), 128'(0));
    check("mid_rst_words_written", 128'(exp_data_q.size()), 128'(0));
    exp_data_q.delete();
    exp_ptr_q.delete();
    exp_ptr_words_q.delete();
    data_pushed = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) frame_buf[i] = 8'($urandom);
    send(16, 4'b0110, 0, 1'b0);
    wait_drain();

    check("exp_data_left", 128'(exp_data_q.size()), 128'(0));
    check("exp_ptr_left", 128'(exp_ptr_q.size()), 128'(0));
    check("err_count", 128'(err_seen), 128'(err_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cell_segmenter.md
CELL_SEGMENTER -- requirements
Module: cell_segmenter

Interface
REQ-001 clk  in  1  sole clock; all logic on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 Parameter MAX_CELLS, default 24, maximum cells per frame (range 1..63).
REQ-004 in_data  in  8  frame byte from ingress MAC path.
REQ-005 in_valid  in  1  in_data valid.
REQ-006 in_last  in  1  qualifies the final byte of the frame.
REQ-007 in_portmap  in  4  destination port bitmap; sampled with the first byte.
REQ-008 in_ready  out  1  byte accepted when in_valid && in_ready.
REQ-009 cell_data_din  out  128  data word to the switch core input cell data FIFO.
REQ-010 cell_data_wr  out  1  one-cycle write strobe for cell_data_din.
REQ-011 cell_ptr_din  out  16  cell pointer word: [11:8] portmap, [5:0] cell count, all other bits 0.
REQ-012 cell_ptr_wr  out  1  one-cycle write strobe for cell_ptr_din.
REQ-013 cell_bp  in  1  switch core input backpressure.
REQ-014 err_oversize  out  1  one-cycle pulse when a frame is truncated.
REQ-015 frame_cnt  out  16  count of pointer words written; wraps 0xFFFF->0.

Function
REQ-016 A cell is 4 words of 128 bits (64 bytes); byte 0 of each word occupies bits [127:120], byte 15 occupies bits [7:0].
REQ-017 States: IDLE, FILL, PAD, PTR, DROP.
REQ-018 IDLE: in_ready = !cell_bp; the first accepted byte latches in_portmap, clears the byte, word and cell counters, and moves to FILL.
REQ-019 FILL: in_ready = 1; cell_bp is ignored until the frame completes, because the core's 96-word margin covers MAX_CELLS=24.
REQ-020 Each 16th accepted byte causes cell_data_wr to be asserted in the following cycle with the packed word; the word index then increments modulo 4, and the cell count increments on wrap.
REQ-021 in_last in FILL: the partial word is zero-filled and written in the next cycle; if word index != 3, go to PAD, otherwise go to PTR.
REQ-022 PAD: in_ready = 0; write one all-zero word per cycle until the cell holds 4 words, then go to PTR.
REQ-023 PTR: in_ready = 0; assert cell_ptr_wr for one cycle with {4'b0, portmap, 2'b0, cells}; increment frame_cnt; return to IDLE.
REQ-024 The pointer word is always written after the last data word of its frame, never before.
REQ-025 A portmap of 0 is forwarded unchanged (the core discards it).
REQ-026 Oversize: an accepted byte that would start cell MAX_CELLS+1 is discarded; pulse err_oversize and go to DROP; the cell count stays MAX_CELLS and the last cell holds exactly 4 words.
REQ-027 DROP: in_ready = 1; discard bytes until in_last, then go to PTR.
REQ-028 in_last on byte 64 of a cell writes no PAD words.
REQ-029 in_valid low in FILL or DROP stalls without timeout; the counters hold.
REQ-030 The cell counter is 6 bits wide and never exceeds MAX_CELLS.

Reset
REQ-031 On rst: state IDLE; in_ready, cell_data_wr, cell_ptr_wr and err_oversize = 0; cell_data_din, cell_ptr_din and frame_cnt = 0; all counters = 0.
REQ-032 Reset mid-frame abandons the frame with no pointer write; the partial words already written are the system's responsibility, because reset is global.

Structure
REQ-033 Shared package holds: CELL_WORDS=4, WORD_BYTES=16, the pointer field positions ([11:8] portmap, [5:0] count), and the state encoding.
REQ-034 One sub-module, cell_byte_packer, performs 8-to-128 packing with zero-fill on flush; the FSM is in cell_segmenter.

Verification
REQ-035 64-byte frame 0x00..0x3F, portmap 4'b0010, bp=0 -> 4 data writes, first word 0x000102...0F, then cell_ptr_din=0x0201, frame_cnt=1.
REQ-036 65-byte frame, portmap 4'b1001 -> 8 data writes, word 5 = {0x40, 120'b0}, words 6-7 zero, ptr=0x0902.
REQ-037 cell_bp=1 in IDLE with in_valid held -> in_ready=0 and no writes; bp released -> frame accepted; bp rising mid-FILL -> no stall.
REQ-038 1600-byte frame -> 96 data writes, one err_oversize pulse, ptr count=24, all 1600 bytes consumed.
REQ-039 rst asserted after byte 20 -> outputs zero immediately; next 16-byte frame -> 4 writes (1 data + 3 pad), ptr count=1, frame_cnt=1.
REQ-040 Back-to-back 1-byte frames with in_valid held -> each produces 4 words + 1 ptr, with in_ready low for 5 cycles per frame.
